// File: rtl/stack_unit_if.sv
// Op/result bundle of the data stack: requester drives ops, stack
// returns TOS/NOS, depth and sticky error flags.
interface stack_unit_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8
);
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op;
    logic [WIDTH-1:0]      op_data;
    logic [WIDTH-1:0]      tos;
    logic [WIDTH-1:0]      nos;
    logic [DEPTH_LOG2+1:0] depth;
    logic                  empty;
    logic                  full;
    logic                  err_ovf;
    logic                  err_udf;
    logic                  clear_err;

    modport master (
        output op_valid, op, op_data, clear_err,
        input  op_ready, tos, nos, depth, empty, full, err_ovf, err_udf
    );

    modport slave (
        input  op_valid, op, op_data, clear_err,
        output op_ready, tos, nos, depth, empty, full, err_ovf, err_udf
    );
endinterface

// File: rtl/stack_unit.sv
// Data stack: TOS/NOS held in registers, deeper entries spilled to a
// synchronous single-port RAM; shrink ops refill NOS in one extra cycle.
module stack_unit #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        resetn,
    stack_unit_if.slave bus
);
    localparam int DW = DEPTH_LOG2 + 2;
    localparam int SW = DEPTH_LOG2;
    localparam logic [DW-1:0] CAP    = DW'((1 << DEPTH_LOG2) + 2);
    localparam logic [DW-1:0] D_ZERO = '0;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);
    localparam logic [SW-1:0] SP_ONE = SW'(1);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DROP = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_OVER = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_REPL = 3'd6;
    localparam logic [2:0] OP_PREP = 3'd7;

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [SW-1:0]    sp_q, sp_d;
    logic             ready_q;
    logic             empty_q;
    logic             full_q;
    logic             ovf_q;
    logic             udf_q;
    logic             ovf_set;
    logic             udf_set;

    logic [WIDTH-1:0] mem [1 << DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;
    logic             ram_we;
    logic             ram_re;
    logic [SW-1:0]    ram_addr;

    logic accept;
    logic ge1;
    logic ge2;
    logic gt2;
    logic is_full;

    assign accept  = bus.op_valid && ready_q;
    assign ge1     = depth_q != D_ZERO;
    assign ge2     = depth_q >= D_TWO;
    assign gt2     = depth_q > D_TWO;
    assign is_full = depth_q == CAP;

    always_comb begin
        state_d  = state_q;
        tos_d    = tos_q;
        nos_d    = nos_q;
        depth_d  = depth_q;
        sp_d     = sp_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = sp_q;
        if (state_q == FILL) begin
            nos_d   = rdata_q;
            state_d = IDLE;
        end else if (accept) begin
            case (bus.op)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    if (is_full) begin
                        ovf_set = 1'b1;
                    end else if ((bus.op == OP_DUP && !ge1) ||
                                 (bus.op == OP_OVER && !ge2)) begin
                        udf_set = 1'b1;
                    end else begin
                        // Old NOS spills to RAM once both registers are live
                        if (ge2) begin
                            ram_we = 1'b1;
                            sp_d   = sp_q + SP_ONE;
                        end
                        nos_d   = tos_q;
                        depth_d = depth_q + D_ONE;
                        if (bus.op == OP_PUSH) tos_d = bus.op_data;
                        else if (bus.op == OP_OVER) tos_d = nos_q;
                    end
                end
                OP_DROP, OP_PREP: begin
                    if ((bus.op == OP_DROP && !ge1) ||
                        (bus.op == OP_PREP && !ge2)) begin
                        udf_set = 1'b1;
                    end else begin
                        tos_d   = (bus.op == OP_DROP) ? nos_q : bus.op_data;
                        depth_d = depth_q - D_ONE;
                        if (gt2) begin
                            ram_re   = 1'b1;
                            ram_addr = sp_q - SP_ONE;
                            sp_d     = sp_q - SP_ONE;
                            state_d  = FILL;
                        end else begin
                            nos_d = '0;
                        end
                    end
                end
                OP_SWAP: begin
                    if (!ge2) begin
                        udf_set = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_REPL: begin
                    if (!ge1) udf_set = 1'b1;
                    else tos_d = bus.op_data;
                end
                OP_NOP: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            sp_q    <= '0;
            ready_q <= 1'b1;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            sp_q    <= sp_d;
            ready_q <= state_d == IDLE;
            empty_q <= depth_d == D_ZERO;
            full_q  <= depth_d == CAP;
            ovf_q   <= ovf_set | (ovf_q & ~bus.clear_err);
            udf_q   <= udf_set | (udf_q & ~bus.clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && resetn) mem[ram_addr] <= nos_q;
        if (ram_re) rdata_q <= mem[ram_addr];
    end

    assign bus.op_ready = ready_q;
    assign bus.tos      = tos_q;
    assign bus.nos      = nos_q;
    assign bus.depth    = depth_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.err_ovf  = ovf_q;
    assign bus.err_udf  = udf_q;
endmodule
